// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multi-cycle main FSM and the shared datapath.
// The FSM side (master) consumes the opcode and memory handshake and drives every select and enable.
interface multicycle_main_fsm_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         op;
    logic               mem_ready;
    logic               branch;
    logic               pc_update;
    logic               ir_write;
    logic               reg_write;
    logic               mem_write;
    logic               adr_src;
    logic [1:0]         result_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic               retire;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, mem_ready,
        output branch, pc_update, ir_write, reg_write, mem_write, adr_src,
               result_src, alu_src_a, alu_src_b, alu_op, retire, illegal, state
    );

    modport slave (
        output op, mem_ready,
        input  branch, pc_update, ir_write, reg_write, mem_write, adr_src,
               result_src, alu_src_a, alu_src_b, alu_op, retire, illegal, state
    );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over the shared datapath, stalling on the memory-ready handshake.
module multicycle_main_fsm #(
    parameter int STATE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_main_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // is_fetch / is_memwrite mark the states whose enables also depend on mem_ready.
    typedef struct packed {
        logic       is_fetch;
        logic       is_memwrite;
        logic       branch;
        logic       pc_update;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.is_fetch   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                c.is_memwrite = 1'b1;
                c.adr_src     = 1'b1;
                c.mem_write   = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
                c.retire    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            S_HALT: begin
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    localparam ctrl_t CTRL_RESET = decode_ctrl(S_FETCH);

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs are registered from the decode of the next state, so they line up with state_q.
    always_comb begin
        ctrl_d = decode_ctrl(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= CTRL_RESET;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Handshake-dependent enables are masked by reset so FETCH cannot fire while held in reset.
    assign bus.ir_write   = ctrl_q.is_fetch & bus.mem_ready & ~reset;
    assign bus.pc_update  = (ctrl_q.pc_update | (ctrl_q.is_fetch & bus.mem_ready)) & ~reset;
    assign bus.retire     = (ctrl_q.retire | (ctrl_q.is_memwrite & bus.mem_ready)) & ~reset;
    assign bus.branch     = ctrl_q.branch;
    assign bus.reg_write  = ctrl_q.reg_write;
    assign bus.mem_write  = ctrl_q.mem_write;
    assign bus.adr_src    = ctrl_q.adr_src;
    assign bus.result_src = ctrl_q.result_src;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.alu_op     = ctrl_q.alu_op;
    assign bus.illegal    = ctrl_q.illegal;
    assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm: stimulus pushes the per-cycle expected
// state/control vector, a negedge monitor pops and compares.
module tb_multicycle_main_fsm;

    localparam logic [3:0] F   = 4'd0;
    localparam logic [3:0] D   = 4'd1;
    localparam logic [3:0] MA  = 4'd2;
    localparam logic [3:0] MR  = 4'd3;
    localparam logic [3:0] MWB = 4'd4;
    localparam logic [3:0] MW  = 4'd5;
    localparam logic [3:0] ER  = 4'd6;
    localparam logic [3:0] EI  = 4'd7;
    localparam logic [3:0] AW  = 4'd8;
    localparam logic [3:0] BQ  = 4'd9;
    localparam logic [3:0] J   = 4'd10;
    localparam logic [3:0] H   = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [3:0]  exp_st_q[$];
    logic [15:0] exp_ctrl_q[$];
    string       exp_nm_q[$];

    multicycle_main_fsm_if #(.STATE_W(4)) bus ();

    multicycle_main_fsm #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control vector per state, straight from the state/output table:
    // {ir_write, pc_update, branch, reg_write, mem_write, adr_src, result_src, srcA, srcB, alu_op, retire, illegal}
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic r);
        logic       ir, pcu, br, rw, mw, adr, ret, ill;
        logic [1:0] rsel, a, b, aop;
        ir = 0; pcu = 0; br = 0; rw = 0; mw = 0; adr = 0; ret = 0; ill = 0;
        rsel = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
        case (st)
            F:   begin b = 2'b10; rsel = 2'b10; ir = mr; pcu = mr; end
            D:   begin a = 2'b01; b = 2'b01; end
            MA:  begin a = 2'b10; b = 2'b01; end
            MR:  begin adr = 1; end
            MWB: begin rsel = 2'b01; rw = 1; ret = 1; end
            MW:  begin adr = 1; mw = 1; ret = mr; end
            ER:  begin a = 2'b10; aop = 2'b10; end
            EI:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            AW:  begin rw = 1; ret = 1; end
            BQ:  begin a = 2'b10; aop = 2'b01; br = 1; ret = 1; end
            J:   begin a = 2'b01; b = 2'b10; pcu = 1; end
            H:   begin ill = 1; end
            default: ;
        endcase
        if (r) begin
            ir = 0; pcu = 0; br = 0; rw = 0; mw = 0; ret = 0;
        end
        return {ir, pcu, br, rw, mw, adr, rsel, a, b, aop, ret, ill};
    endfunction

    task automatic step(input string nm, input logic [6:0] o, input logic mr, input logic [3:0] st);
        bus.op        = o;
        bus.mem_ready = mr;
        exp_st_q.push_back(st);
        exp_ctrl_q.push_back(exp_ctrl(st, mr, rst));
        exp_nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_st_q.size() > 0) begin
            logic [3:0]  e_st;
            logic [15:0] e_ctrl;
            logic [15:0] act;
            string       nm;
            e_st   = exp_st_q.pop_front();
            e_ctrl = exp_ctrl_q.pop_front();
            nm     = exp_nm_q.pop_front();
            act = {bus.ir_write, bus.pc_update, bus.branch, bus.reg_write, bus.mem_write,
                   bus.adr_src, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                   bus.retire, bus.illegal};
            n_cmp = n_cmp + 1;
            if (bus.state !== e_st) begin
                n_bad = n_bad + 1;
                $display("FAIL %s state: got %0d expected %0d", nm, bus.state, e_st);
            end
            n_cmp = n_cmp + 1;
            if (act !== e_ctrl) begin
                n_bad = n_bad + 1;
                $display("FAIL %s ctrl: got %b expected %b", nm, act, e_ctrl);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.op = OP_R;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Held in reset with mem_ready high: FETCH selects, no enables.
        step("reset0", OP_R, 1'b1, F);
        step("reset1", OP_R, 1'b1, F);
        rst = 1'b0;

        // R-type: 4 cycles, writeback in cycle 4
        step("r_fetch", OP_R, 1'b1, F);
        step("r_dec",   OP_R, 1'b0, D);
        step("r_exe",   OP_R, 1'b1, ER);
        step("r_wb",    OP_R, 1'b0, AW);

        // I-type with one fetch wait cycle
        step("i_fwait", OP_I, 1'b0, F);
        step("i_fetch", OP_I, 1'b1, F);
        step("i_dec",   OP_I, 1'b1, D);
        step("i_exe",   OP_I, 1'b1, EI);
        step("i_wb",    OP_I, 1'b1, AW);

        // lw with two MEMREAD wait cycles: 7 cycles
        step("lw_fetch", OP_LW, 1'b1, F);
        step("lw_dec",   OP_LW, 1'b1, D);
        step("lw_adr",   OP_LW, 1'b0, MA);
        step("lw_rd0",   OP_LW, 1'b0, MR);
        step("lw_rd1",   OP_LW, 1'b0, MR);
        step("lw_rd2",   OP_LW, 1'b1, MR);
        step("lw_wb",    OP_LW, 1'b0, MWB);

        // sw with one wait: mem_write for exactly two cycles, retire on exit
        step("sw_fetch", OP_SW, 1'b1, F);
        step("sw_dec",   OP_SW, 1'b1, D);
        step("sw_adr",   OP_SW, 1'b1, MA);
        step("sw_wr0",   OP_SW, 1'b0, MW);
        step("sw_wr1",   OP_SW, 1'b1, MW);

        // beq: 3 cycles
        step("beq_fetch", OP_BEQ, 1'b1, F);
        step("beq_dec",   OP_BEQ, 1'b1, D);
        step("beq_exe",   OP_BEQ, 1'b1, BQ);

        // jal: JAL then ALUWB
        step("jal_fetch", OP_JAL, 1'b1, F);
        step("jal_dec",   OP_JAL, 1'b1, D);
        step("jal_jal",   OP_JAL, 1'b1, J);
        step("jal_wb",    OP_JAL, 1'b1, AW);

        // Reset in the middle of a store wait: aborts with no mem_write
        step("swr_fetch", OP_SW, 1'b1, F);
        step("swr_dec",   OP_SW, 1'b1, D);
        step("swr_adr",   OP_SW, 1'b1, MA);
        step("swr_wr0",   OP_SW, 1'b0, MW);
        rst = 1'b1;
        step("swr_rst",   OP_SW, 1'b1, F);
        rst = 1'b0;

        // Illegal opcode: HALT for 20 cycles regardless of mem_ready
        step("bad_fetch", OP_BAD, 1'b1, F);
        step("bad_dec",   OP_BAD, 1'b1, D);
        for (int i = 0; i < 20; i++) begin
            step("halt", OP_R, (i % 2 == 0) ? 1'b1 : 1'b0, H);
        end
        rst = 1'b1;
        step("halt_rst", OP_R, 1'b1, F);
        rst = 1'b0;

        // Normal operation resumes after the halt reset
        step("post_fetch", OP_R, 1'b1, F);
        step("post_dec",   OP_R, 1'b1, D);
        step("post_exe",   OP_R, 1'b1, ER);
        step("post_wb",    OP_R, 1'b1, AW);
        step("post_next",  OP_R, 1'b0, F);

        repeat (2) @(negedge clk);
        #1;
        if (exp_st_q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain: got %0d pending expected 0", exp_st_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
